// File: rtl/swerv_types.sv
// Shared types for the EXU ALU arbiter slice.
//   alu_pkt_t      : ALU opcode decode bundle carried with each operation
//   exu_arb_req_t  : one requester's operands {a, b, pc, brimm, ap}
//   EXU_ARB_NREQ   : number of requesters sharing the ALU
package swerv_types;

  localparam int EXU_ARB_NREQ = 2;

  typedef struct packed {
    logic land;
    logic lor;
    logic lxor;
    logic sll;
    logic srl;
    logic sra;
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic add;
    logic sub;
    logic slt;
    logic unsign;
    logic jal;
  } alu_pkt_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:1] pc;
    logic [12:1] brimm;
    alu_pkt_t    ap;
  } exu_arb_req_t;

endpackage

// File: rtl/exu_alu_arb_cnt.sv
// Saturating event counter with synchronous clear.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear, wins over en
//   en       : count one event this cycle
//   cnt      : current count, sticks at all-ones
module exu_alu_arb_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/exu_alu_arb.sv
// Two-requester arbiter in front of a single-cycle ALU.
// Requester 0 has fixed priority; requester 1 is force-granted after
// STARVE_MAX consecutive lost cycles. The owner of the in-flight operation
// is tracked so its result strobe (rsp_valid) is steered back one cycle later.
// Optional per-requester branch / taken-branch counters are built when the
// macro EXU_ALU_ARB_BRCNT_EN is defined; otherwise br_cnt/brt_cnt read 0.
//   clk, rst            : clock, async active-high reset
//   freeze, flush       : pipeline hold / kill
//   req_valid/ready/pkt : per-requester handshake and operands
//   alu_valid, alu_pkt  : issue strobe and winner's packet to the ALU
//   alu_is_branch(_t)   : branch info for the in-flight op
//   rsp_valid           : one-hot result owner
//   cnt_clr             : clear all branch counters
//   br_cnt, brt_cnt     : per-requester branch / taken-branch counts
module exu_alu_arb
  import swerv_types::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    freeze,
  input  logic                                    flush,
  input  logic [EXU_ARB_NREQ-1:0]                 req_valid,
  output logic [EXU_ARB_NREQ-1:0]                 req_ready,
  input  exu_arb_req_t [EXU_ARB_NREQ-1:0]         req_pkt,
  output logic                                    alu_valid,
  output exu_arb_req_t                            alu_pkt,
  input  logic                                    alu_is_branch,
  input  logic                                    alu_is_branch_t,
  output logic [EXU_ARB_NREQ-1:0]                 rsp_valid,
  input  logic                                    cnt_clr,
  output logic [EXU_ARB_NREQ-1:0][CNT_W-1:0]      br_cnt,
  output logic [EXU_ARB_NREQ-1:0][CNT_W-1:0]      brt_cnt
);

  localparam int SW = 4;

  logic [SW-1:0]           starve_cnt;
  logic                    inflight_v;
  logic                    inflight_id;
  logic [EXU_ARB_NREQ-1:0] grant;
  logic                    starved;

  assign starved = req_valid[0] && req_valid[1] && (starve_cnt == SW'(STARVE_MAX));

  // rst gates the combinational grant so every output is quiet in reset.
  always_comb begin
    grant = '0;
    if (!rst && !freeze && !flush) begin
      if (starved)           grant = 2'b10;
      else if (req_valid[0]) grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
    end
  end

  assign req_ready = grant;
  assign alu_valid = |grant;

  always_comb begin
    alu_pkt = '0;
    if (grant[0])      alu_pkt = req_pkt[0];
    else if (grant[1]) alu_pkt = req_pkt[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (flush) begin
      starve_cnt <= '0;
    end else if (!freeze) begin
      if (!req_valid[1] || grant[1])          starve_cnt <= '0;
      else if (starve_cnt < SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // grant is already zero under flush, so the load value is simply the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_v  <= 1'b0;
      inflight_id <= 1'b0;
    end else if (!freeze) begin
      inflight_v  <= |grant;
      inflight_id <= grant[1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (inflight_v && !flush) rsp_valid[inflight_id] = 1'b1;
  end

`ifdef EXU_ALU_ARB_BRCNT_EN
  for (genvar i = 0; i < EXU_ARB_NREQ; i++) begin : g_cnt
    exu_alu_arb_cnt #(.W(CNT_W)) u_br (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (rsp_valid[i] & alu_is_branch),
      .cnt (br_cnt[i])
    );
    exu_alu_arb_cnt #(.W(CNT_W)) u_brt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (rsp_valid[i] & alu_is_branch_t),
      .cnt (brt_cnt[i])
    );
  end
`else
  logic unused_brcnt;
  assign unused_brcnt = ^{alu_is_branch, alu_is_branch_t, cnt_clr};
  assign br_cnt  = '0;
  assign brt_cnt = '0;
`endif

endmodule

// File: doc/exu_alu_arb.md
EXU_ALU_ARB -- requirements
Module: exu_alu_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, the number of consecutive lost cycles after which requester 1 is force-granted (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 32, the width of each branch-event counter.
REQ-003 clk  in  1  single clock; all flops sample on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 freeze  in  1  pipeline freeze; no grants and in-flight state held.
REQ-006 flush  in  1  pipeline flush; kills the current grant and the in-flight response.
REQ-007 req_valid  in  2  per-requester request valid.
REQ-008 req_ready  out  2  per-requester grant; a transfer occurs when valid and ready are both high.
REQ-009 req_pkt  in  2 x exu_arb_req_t  per-requester operands {a[31:0], b[31:0], pc[31:1], brimm[12:1], ap}.
REQ-010 alu_valid  out  1  issue strobe to the ALU, also used as its enable.
REQ-011 alu_pkt  out  exu_arb_req_t  the winner's packet; all-zero when there is no grant.
REQ-012 alu_is_branch, alu_is_branch_t  in  1 each  branch and taken-branch indications returned by the ALU for the in-flight operation.
REQ-013 rsp_valid  out  2  one-hot response strobe naming the owner of the ALU result.
REQ-014 cnt_clr  in  1  synchronous clear of all branch counters.
REQ-015 br_cnt, brt_cnt  out  2 x CNT_W  per-requester branch and taken-branch counts.

Function
REQ-016 Grant SHALL be combinational: with freeze=0 and flush=0, grant requester 0 if it is valid, otherwise requester 1 if it is valid.
REQ-017 Exception to REQ-016: when both requesters are valid and starve_cnt==STARVE_MAX, grant requester 1.
REQ-018 Grant SHALL be forced to none while freeze=1 or flush=1.
REQ-019 req_ready SHALL equal the grant vector, which is at most one-hot; alu_valid = |grant.
REQ-020 starve_cnt SHALL update as follows:
- Increments by 1 in each non-frozen cycle where requester 1 is valid and not granted.
- Clears when requester 1 is granted, when req_valid[1]=0, or when flush=1.
- Holds while freeze=1 (flush takes precedence and clears it).
- Never exceeds STARVE_MAX.
REQ-021 The in-flight register {inflight_v, inflight_id} SHALL load {grant & ~flush, winner id} on each non-frozen cycle and hold while freeze=1.
REQ-022 rsp_valid[inflight_id] SHALL equal inflight_v & ~flush, so responses appear exactly one cycle after the grant, matching the ALU's single-flop latency.
REQ-023 A flush in the grant cycle SHALL suppress the response; a flush in the response cycle SHALL suppress rsp_valid.
REQ-024 Back-to-back grants to the same or to alternating requesters SHALL be legal on every cycle.

Reset
REQ-025 While rst=1 the following SHALL be 0: req_ready, alu_valid, alu_pkt, rsp_valid, starve_cnt, inflight_v, inflight_id, br_cnt and brt_cnt.
REQ-026 Deassertion of rst mid-request SHALL issue the first grant in the first cycle after deassertion.

Configuration
REQ-027 Macro EXU_ALU_ARB_BRCNT_EN SHALL control the branch counters.
REQ-028 With EXU_ALU_ARB_BRCNT_EN defined, branch counting SHALL behave as follows:
- A cycle with rsp_valid[i] and alu_is_branch increments br_cnt[i].
- A cycle with rsp_valid[i] and alu_is_branch_t increments brt_cnt[i].
- Counters saturate at all-ones.
- cnt_clr has priority over an increment in the same cycle.
REQ-029 Without EXU_ALU_ARB_BRCNT_EN, ports SHALL remain present, br_cnt and brt_cnt SHALL be constant 0, and alu_is_branch, alu_is_branch_t and cnt_clr SHALL be ignored.

Structure
REQ-030 The typedef exu_arb_req_t and the constant EXU_ARB_NREQ=2 SHALL live in swerv_types alongside alu_pkt_t.
REQ-031 One sub-module, exu_alu_arb_cnt, SHALL implement the saturating counter with clear and enable; it is instantiated 4 times under the macro.

Verification
REQ-032 Both requesters valid continuously, STARVE_MAX=4 -> grants 0,0,0,0,1,0,0,0,0,1...; rsp_valid follows each grant by 1 cycle.
REQ-033 Only requester 1 valid for 3 cycles with pkt a=5, b=7 -> req_ready=2'b10 each cycle, alu_pkt.a=5, rsp_valid=2'b10 in cycles 2-4.
REQ-034 Grant to requester 0 at cycle N with flush=1 at N+1 -> rsp_valid=0 at N+1; starve_cnt=0 after N+1.
REQ-035 freeze=1 for 2 cycles mid-stream with starve_cnt=3 -> req_ready=0, starve_cnt=3 held, rsp_valid held; resumes unchanged on release.
REQ-036 With the macro: 3 responses to requester 0 with is_branch=1 and is_branch_t=1 on 2 of them -> br_cnt[0]=3, brt_cnt[0]=2.
REQ-037 With the macro: counter preset near all-ones saturates; cnt_clr together with an increment -> 0.
REQ-038 Without the macro, the same stimulus as REQ-036 -> br_cnt[0]=0.
REQ-039 rst asserted asynchronously mid-grant -> all outputs 0 immediately.
